// File: rtl/output_stage_pkg.sv
// rtl/output_stage_pkg.sv - output stage types, widths and flit helpers
`include "params.vh"
package output_stage_pkg;
  localparam int DW = `DW;
  localparam int CN = `CN;
  localparam int FIFO_DEPTH = `FIFO_DEPTH;
  localparam int PTR_W = (CN > 1) ? $clog2(CN) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;
  typedef logic [1:0] flit_type_t;

  function automatic flit_type_t flit_type(input logic [DW-1:0] flit);
    return flit[DW-1:DW-2];
  endfunction

  function automatic logic is_tail(input logic [DW-1:0] flit);
    return (flit_type(flit) == `FLIT_TAIL) || (flit_type(flit) == `FLIT_SINGLE);
  endfunction

  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [CN-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < CN; i++) begin
      if (oh[i]) idx = idx | PTR_W'(i);
    end
    return idx;
  endfunction
endpackage

// File: rtl/output_stage_if.sv
// rtl/output_stage_if.sv - flit stream bundle (valid/data/ready) with producer/consumer views
interface output_stage_if;
  import output_stage_pkg::*;
  logic          valid;
  logic [DW-1:0] data;
  logic          ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/params.vh
// rtl/params.vh - shared router widths and flit-type codes
`ifndef PARAMS_VH
`define PARAMS_VH
`define DW 34
`define CN 4
`define FIFO_DEPTH 2
`define FLIT_HEAD 2'b10
`define FLIT_BODY 2'b00
`define FLIT_TAIL 2'b01
`define FLIT_SINGLE 2'b11
`endif

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, searching upward from ptr with wrap
`include "params.vh"
module rr_arbiter
  import output_stage_pkg::*;
(
  input  logic [`CN-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [`CN-1:0] gnt
);
  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < CN; i++) begin
      idx = PTR_W'((int'(ptr) + i) % CN);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/output_stage.sv
// rtl/output_stage.sv - router output port: per-packet VC arbitration plus 2-entry skid buffer
`include "params.vh"
module output_stage
  import output_stage_pkg::*;
#(
  parameter int ARB_INIT = 0
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [`CN-1:0] reqVC_i,
  output logic [`CN-1:0] selOutVC_o,
  output logic           VCgranted_o,
  input  logic           valid_i,
  input  logic [`DW-1:0] data_i,
  output logic           ready_o,
  output logic           valid_o,
  output logic [`DW-1:0] data_o,
  input  logic           ready_i
);
  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q;
  logic [`CN-1:0]   sel_q, gnt;
  logic [`DW-1:0]   mem [2];
  logic             wr_q, rd_q;
  logic [CNT_W-1:0] count_q;
  logic             accept, pop, start, in_pkt_q;

  rr_arbiter u_arb (.req(reqVC_i), .ptr(ptr_q), .gnt(gnt));

  assign accept      = valid_i && ready_o;
  assign pop         = valid_o && ready_i;
  assign start       = (state_q == IDLE) && (reqVC_i != '0);
  assign ready_o     = (state_q != IDLE) && (count_q < CNT_W'(FIFO_DEPTH));
  assign valid_o     = (count_q != '0);
  assign data_o      = mem[rd_q];
  assign VCgranted_o = (state_q == GRANT);
  assign selOutVC_o  = sel_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (reqVC_i != '0) state_d = GRANT;
      GRANT:   state_d = (accept && is_tail(data_i)) ? IDLE : BUSY;
      BUSY:    if (accept && is_tail(data_i)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= PTR_W'(ARB_INIT);
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        sel_q <= gnt;
        ptr_q <= PTR_W'((int'(onehot_to_idx(gnt)) + 1) % CN);
      end else if (state_d == IDLE) begin
        sel_q <= '0;
      end
    end
  end

  // Buffer state survives the end of a packet; it drains independently of the FSM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      if (accept) wr_q <= ~wr_q;
      if (pop)    rd_q <= ~rd_q;
      count_q <= count_q + CNT_W'(accept) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_q] <= data_i;
  end

  // Marks that the current packet already delivered a flit, so a later head is a second head.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                  in_pkt_q <= 1'b0;
    else if (state_d == IDLE)   in_pkt_q <= 1'b0;
    else if (accept)            in_pkt_q <= 1'b1;
  end

  head_in_busy: assert property (@(posedge clk) disable iff (!rstn)
    !(accept && in_pkt_q && (flit_type(data_i) == `FLIT_HEAD)));
endmodule

// File: doc/output_stage.md
OUTPUT_STAGE -- requirements
Module: output_stage

Interface
REQ-001 SHALL have parameter ARB_INIT, default 0, meaning the index of the input channel that holds highest arbitration priority after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port reqVC_i  input  `CN  one bit per input stage requesting this output.
REQ-005 SHALL have port selOutVC_o  output  `CN  one-hot grant, held for the whole packet.
REQ-006 SHALL have port VCgranted_o  output  1  single-cycle pulse, asserted in the cycle a grant is issued.
REQ-007 SHALL have port valid_i  input  1  flit valid from the crossbar.
REQ-008 SHALL have port data_i  input  `DW  flit from the crossbar; bits [`DW-1:`DW-2] carry the flit type.
REQ-009 SHALL have port ready_o  output  1  space available, sent to the crossbar.
REQ-010 SHALL have port valid_o  output  1  flit valid toward the link or neighbour router.
REQ-011 SHALL have port data_o  output  `DW  flit toward the link or neighbour router.
REQ-012 SHALL have port ready_i  input  1  downstream accept.

Function
REQ-013 SHALL decode flit types as: 2'b10 head, 2'b00 body, 2'b01 tail, 2'b11 single (head and tail in one flit).
REQ-014 SHALL implement the FSM states IDLE, GRANT and BUSY.
- IDLE: if reqVC_i != 0, go to GRANT.
- GRANT: lasts exactly one cycle; go to BUSY.
- BUSY: stay until the packet's tail or single flit is accepted on the input side.
REQ-015 SHALL, on the IDLE->GRANT edge, choose the winner round-robin, searching upward from the priority pointer with wrap from `CN-1 to 0.
- selOutVC_o becomes one-hot(winner) in GRANT.
- VCgranted_o = 1 in GRANT only.
- The pointer becomes (winner+1) mod `CN.
REQ-016 SHALL hold selOutVC_o stable through GRANT and BUSY, and drive 0 in IDLE.
REQ-017 SHALL accept an input flit when valid_i && ready_o, in GRANT or BUSY only; in IDLE, ready_o = 0.
REQ-018 SHALL, when a tail or single flit is accepted, go to IDLE on the next edge.
- selOutVC_o clears in that same edge.
- Any pending request is arbitrated in the following cycle, giving one mandatory bubble.
REQ-019 SHALL buffer flits in a 2-entry FIFO (skid buffer).
- ready_o = (FSM != IDLE) && (count < 2).
- valid_o = (count != 0); data_o = the oldest entry.
- Latency valid_i to valid_o is exactly 1 cycle when the buffer is empty.
REQ-020 SHALL support a simultaneous push and pop: the count is unchanged and ordering is preserved.
- A push when count == 2 is impossible because ready_o = 0.
- A pop when count == 0 is ignored.
REQ-021 SHALL keep data_o stable while valid_o && !ready_i.
REQ-022 SHALL drop the input-stage request of a withdrawn requester without error.
- This applies to a reqVC_i bit that deasserts during BUSY.
- The grant persists until the tail flit.
REQ-023 SHALL flag a head flit received in BUSY as a protocol error in simulation only (assertion); the RTL passes it through unchanged.

Reset
REQ-024 SHALL, on rstn = 0, asynchronously force the following, independent of clk:
- FSM = IDLE.
- Pointer = ARB_INIT.
- FIFO count = 0.
- selOutVC_o = 0, VCgranted_o = 0, valid_o = 0, ready_o = 0.
REQ-025 SHALL leave data_o contents undefined under reset; benches check data_o only when valid_o = 1.
REQ-026 SHALL discard any in-flight packet and grant when reset is asserted mid-packet; after release, the block restarts from IDLE.

Structure
REQ-027 SHALL take `DW, `CN, `FIFO_DEPTH and the flit-type codes (FLIT_HEAD, FLIT_BODY, FLIT_TAIL, FLIT_SINGLE) from params.vh; no local redefinition.
REQ-028 SHALL place round-robin selection in one sub-module, rr_arbiter, with:
- inputs: request, pointer;
- output: one-hot grant;
- purely combinational.
REQ-029 SHALL keep the FSM, the pointer register and the 2-entry buffer in output_stage itself.

Verification
REQ-030 SHALL cover: reqVC_i = 4'b0110, ARB_INIT = 0 -> GRANT with selOutVC_o = 4'b0010, VCgranted_o pulse of 1 cycle, pointer = 2.
REQ-031 SHALL cover: a 4-flit packet (head, body, body, tail) with ready_i = 1 -> data_o shows the same flits 1 cycle delayed, then FSM = IDLE and selOutVC_o = 0 on the edge after the tail is accepted.
REQ-032 SHALL cover: ready_i = 0 for 5 cycles mid-packet -> count = 2, ready_o = 0, data_o stable; release -> no flit lost or duplicated.
REQ-033 SHALL cover: reqVC_i = 4'b1111 held continuously -> grants cycle 0,1,2,3,0 with one bubble between packets.
REQ-034 SHALL cover: a single flit (2'b11) -> GRANT, accept, IDLE in 3 cycles total; valid_o high for exactly 1 cycle when ready_i = 1.
REQ-035 SHALL cover: rstn pulsed low while count = 2 in BUSY -> all outputs 0 immediately, with no clk edge required; the next request is granted from ARB_INIT.
